// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
// One quotient bit per cycle, fixed 33-cycle latency, cancellable by annul_i.
// result_o = {remainder, quotient}; remainder sign follows the dividend and
// the quotient truncates toward zero.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs_s;
  logic [31:0] op2_abs_s;
  logic [32:0] diff_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Two's-complement magnitude when the operand is to be treated as negative.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    abs32 = neg ? (~v + 32'd1) : v;
  endfunction

  assign op1_abs_s = abs32(opdata1_i, signed_div_i & opdata1_i[31]);
  assign op2_abs_s = abs32(opdata2_i, signed_div_i & opdata2_i[31]);

  // The partial remainder is 33 bits wide (work[64:32]) after the shift, so
  // bit 64 takes part in the trial subtraction; otherwise divisors with bit 31
  // set would lose the top remainder bit.
  assign diff_s = work_q[64:32] - {1'b0, divisor_q};

  assign quot_s = qneg_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
  assign rem_s  = rneg_q ? (32'd0 - work_q[64:33]) : work_q[64:33];

  // Next-state and datapath decisions for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            work_d    = {32'd0, op1_abs_s, 1'b0};
            divisor_d = op2_abs_s;
            cnt_d     = 6'd0;
            qneg_d    = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            rneg_d    = signed_div_i & opdata1_i[31];
          end
        end else begin
          state_d = S_FREE;
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = 64'd0;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q == 6'd32) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_s, quot_s};
        end else begin
          if (diff_s[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff_s[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          state_d = S_END;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
